// File: rtl/lsf_rbin_pkg.sv
// Shared types and helpers for the LSF r-bin stream (producer side and histogram side).
package lsf_rbin_pkg;

  typedef logic [7:0] rbin_t;

  // Bin code sent for hits outside the histogram range; the histogram ignores it.
  localparam rbin_t RBIN_OOR  = 8'hFF;
  localparam int    RBINS_MAX = 128;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } tx_state_e;

  // Eight-bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    r = (v == 8'hFF) ? v : v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/rbin_skid_buffer.sv
// Two-entry skid buffer between the binning stage and the r_bin stream.
// The upstream ready is a flop computed from next-cycle occupancy, so there is
// no combinational path from m_ready back to s_ready. empty_nxt tells the
// owner that the buffer will be empty after the current edge.
module rbin_skid_buffer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         empty_nxt
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         s_ready_q, s_ready_d;
  logic         push, pop;

  assign push = s_valid & s_ready_q;
  assign pop  = m_ready & (count_q != 2'd0);

  // Occupancy update: head is always the oldest entry, tail only holds the skid slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = s_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data;
        end else if (push) begin
          tail_d  = s_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // s_ready is low while full, so only a pop can happen here.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
    s_ready_d = (count_d != 2'd2);
  end

  // Buffer storage and registered upstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      s_ready_q <= 1'b1;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = head_q;
  assign empty_nxt = (count_d == 2'd0);

endmodule

// File: rtl/rbin_stream_tx.sv
// Producer side of the LSF r-bin stream: quantises hit r values into histogram
// bins, streams them through a skid buffer, and sequences reset_rbins/enable_V
// around each event (CLEAR -> STREAM -> DRAIN -> DONE).
// Build option RBIN_DROP_OOR_EN: out-of-range hits are counted but not sent.
module rbin_stream_tx
  import lsf_rbin_pkg::*;
#(
  parameter int RBINS        = 128,
  parameter int R_W          = 16,
  parameter int R_MIN        = 0,
  parameter int BIN_SHIFT    = 4,
  parameter int CLR_CYCLES   = 130,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           event_start,
  input  logic [R_W-1:0] hit_r_TDATA,
  input  logic           hit_r_TVALID,
  input  logic           hit_r_TLAST,
  output logic           hit_r_TREADY,
  output logic [7:0]     r_bin_V_TDATA,
  output logic           r_bin_V_TVALID,
  input  logic           r_bin_V_TREADY,
  output logic           reset_rbins,
  output logic           enable_V,
  output logic           event_done,
  output logic           busy,
  output logic [7:0]     hits_sent,
  output logic [7:0]     oor_count,
  output logic           start_err
);

  localparam logic [7:0] CLR_LAST   = 8'(CLR_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  // r is widened by one bit before subtracting R_MIN so the difference cannot overflow.
  function automatic rbin_t quantise(input logic [R_W-1:0] r);
    logic signed [R_W:0] diff;
    logic [R_W:0]        idx;
    rbin_t               res;
    diff = $signed({r[R_W-1], r}) - $signed((R_W+1)'(R_MIN));
    idx  = $unsigned(diff) >> BIN_SHIFT;
    if (!diff[R_W] && (idx < (R_W+1)'(RBINS)))
      res = {1'b0, idx[6:0]};
    else
      res = RBIN_OOR;
    return res;
  endfunction

  tx_state_e  state_q;
  logic [7:0] clr_cnt_q;
  logic [7:0] drain_cnt_q;
  logic       reset_rbins_q;
  logic       enable_q;
  logic       done_q;
  logic       tready_en_q;
  logic       drop_last_q;
  logic [7:0] hits_q;
  logic [7:0] oor_q;
  logic       start_err_q;

  rbin_t      bin_w;
  logic       oor_w;
  logic       acc, acc_last, pop;
  logic       push_valid, drop_last;
  logic       skid_s_ready, skid_m_valid, empty_nxt;
  logic [8:0] skid_m_data;
  logic       m_last, drain_go;

  assign bin_w    = quantise(hit_r_TDATA);
  assign oor_w    = (bin_w == RBIN_OOR);
  assign acc      = hit_r_TVALID & hit_r_TREADY;
  assign acc_last = acc & hit_r_TLAST;
  assign pop      = skid_m_valid & r_bin_V_TREADY;
  assign m_last   = skid_m_data[8];

`ifdef RBIN_DROP_OOR_EN
  // Out-of-range hits are consumed without entering the buffer.
  assign push_valid = hit_r_TVALID & tready_en_q & ~oor_w;
  assign drop_last  = acc_last & oor_w;
`else
  assign push_valid = hit_r_TVALID & tready_en_q;
  assign drop_last  = 1'b0;
`endif

  // The event ends once the last hit has left (or was dropped) and the buffer is empty.
  assign drain_go = empty_nxt & ((pop & m_last) | drop_last | drop_last_q);

  rbin_skid_buffer #(
    .W(9)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (push_valid),
    .s_ready  (skid_s_ready),
    .s_data   ({hit_r_TLAST, bin_w}),
    .m_valid  (skid_m_valid),
    .m_ready  (r_bin_V_TREADY),
    .m_data   (skid_m_data),
    .empty_nxt(empty_nxt)
  );

  // Event sequencer with registered histogram control pins and per-event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clr_cnt_q     <= 8'd0;
      drain_cnt_q   <= 8'd0;
      reset_rbins_q <= 1'b0;
      enable_q      <= 1'b0;
      done_q        <= 1'b0;
      tready_en_q   <= 1'b0;
      drop_last_q   <= 1'b0;
      hits_q        <= 8'd0;
      oor_q         <= 8'd0;
      start_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (event_start && (state_q != IDLE))
        start_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (event_start) begin
            state_q       <= CLEAR;
            reset_rbins_q <= 1'b1;
            clr_cnt_q     <= 8'd0;
            hits_q        <= 8'd0;
            oor_q         <= 8'd0;
            drop_last_q   <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q       <= STREAM;
            reset_rbins_q <= 1'b0;
            enable_q      <= 1'b1;
            tready_en_q   <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 8'd1;
          end
        end
        STREAM: begin
          if (pop)
            hits_q <= sat_inc8(hits_q);
          if (acc && oor_w)
            oor_q <= sat_inc8(oor_q);
          if (acc_last)
            tready_en_q <= 1'b0;
          if (drop_last)
            drop_last_q <= 1'b1;
          if (drain_go) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 8'd0;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q  <= DONE;
            enable_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit_r_TREADY   = tready_en_q & skid_s_ready;
  assign r_bin_V_TDATA  = skid_m_data[7:0];
  assign r_bin_V_TVALID = skid_m_valid;
  assign reset_rbins    = reset_rbins_q;
  assign enable_V       = enable_q;
  assign event_done     = done_q;
  assign busy           = (state_q != IDLE);
  assign hits_sent      = hits_q;
  assign oor_count      = oor_q;
  assign start_err      = start_err_q;

endmodule

// File: tb/tb_rbin_stream_tx.sv
// Scoreboard bench for rbin_stream_tx (default parameters). Honours RBIN_DROP_OOR_EN.
module tb_rbin_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        event_start;
  logic [15:0] hit_r_TDATA;
  logic        hit_r_TVALID;
  logic        hit_r_TLAST;
  logic        hit_r_TREADY;
  logic [7:0]  r_bin_V_TDATA;
  logic        r_bin_V_TVALID;
  logic        r_bin_V_TREADY;
  logic        reset_rbins;
  logic        enable_V;
  logic        event_done;
  logic        busy;
  logic [7:0]  hits_sent;
  logic [7:0]  oor_count;
  logic        start_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_hs_cyc = 0;
  int          exp_hits = 0;
  int          exp_oor  = 0;
  logic [7:0]  sb_q[$];

  always #5 clk = ~clk;

  rbin_stream_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .event_start   (event_start),
    .hit_r_TDATA   (hit_r_TDATA),
    .hit_r_TVALID  (hit_r_TVALID),
    .hit_r_TLAST   (hit_r_TLAST),
    .hit_r_TREADY  (hit_r_TREADY),
    .r_bin_V_TDATA (r_bin_V_TDATA),
    .r_bin_V_TVALID(r_bin_V_TVALID),
    .r_bin_V_TREADY(r_bin_V_TREADY),
    .reset_rbins   (reset_rbins),
    .enable_V      (enable_V),
    .event_done    (event_done),
    .busy          (busy),
    .hits_sent     (hits_sent),
    .oor_count     (oor_count),
    .start_err     (start_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference binning for R_MIN=0, BIN_SHIFT=4, RBINS=128.
  function automatic logic [7:0] model_bin(input logic [15:0] r);
    int v;
    logic [7:0] b;
    v = int'($signed(r));
    if (v < 0 || v >= 2048) b = 8'hFF;
    else                    b = 8'(v / 16);
    return b;
  endfunction

  function automatic int sat255(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // One clock: observe both handshakes mid-cycle, then step to just after the next edge.
  task automatic tick();
    logic [7:0] e;
    logic [7:0] b;
    @(negedge clk);
    if (r_bin_V_TVALID && r_bin_V_TREADY) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_bin", 32'(r_bin_V_TDATA), 32'(e));
      end
      last_hs_cyc = cyc;
    end
    if (hit_r_TVALID && hit_r_TREADY) begin
      b = model_bin(hit_r_TDATA);
      if (b == 8'hFF) exp_oor++;
`ifdef RBIN_DROP_OOR_EN
      if (b != 8'hFF) begin
        sb_q.push_back(b);
        exp_hits++;
      end
`else
      sb_q.push_back(b);
      exp_hits++;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_event();
    int   n;
    logic bad;
    exp_hits = 0;
    exp_oor  = 0;
    sb_q.delete();
    event_start = 1'b1;
    tick();
    event_start = 1'b0;
    n   = 0;
    bad = 1'b0;
    while (reset_rbins && n < 300) begin
      if (enable_V || hit_r_TREADY || hits_sent != 8'd0 || oor_count != 8'd0) bad = 1'b1;
      n++;
      tick();
    end
    chk("clr_len", 32'(n), 32'd130);
    chk("clr_quiet", 32'(bad), 32'd0);
    chk("stream_en", 32'(enable_V), 32'd1);
    chk("stream_tready", 32'(hit_r_TREADY), 32'd1);
  endtask

  task automatic send_hit(input logic [15:0] r, input logic last);
    int   n;
    logic acc;
    hit_r_TDATA  = r;
    hit_r_TLAST  = last;
    hit_r_TVALID = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = hit_r_TREADY;
      tick();
      n++;
    end
    hit_r_TVALID = 1'b0;
    hit_r_TLAST  = 1'b0;
    chk("hit_accept", 32'(acc), 32'd1);
  endtask

  task automatic finish_event(input logic check_dist);
    int   n;
    logic en_low;
    n      = 0;
    en_low = 1'b0;
    while (!event_done && n < 100) begin
      if (!enable_V) en_low = 1'b1;
      tick();
      n++;
    end
    chk("done_seen", 32'(event_done), 32'd1);
    chk("done_en_low", 32'(enable_V), 32'd0);
    chk("drain_en_high", 32'(en_low), 32'd0);
    if (check_dist) chk("drain_len", 32'(cyc - last_hs_cyc), 32'd5);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("hits_sent", 32'(hits_sent), 32'(sat255(exp_hits)));
    chk("oor_count", 32'(oor_count), 32'(sat255(exp_oor)));
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulse", 32'(event_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    event_start    = 1'b0;
    hit_r_TDATA    = 16'h0;
    hit_r_TVALID   = 1'b0;
    hit_r_TLAST    = 1'b0;
    r_bin_V_TREADY = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'({hit_r_TREADY, r_bin_V_TDATA, r_bin_V_TVALID, reset_rbins, enable_V,
                              event_done, busy, hits_sent, oor_count, start_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Clear phase, then in-range binning with one-cycle latency.
    start_event();
    send_hit(16'h0125, 1'b0);
    chk("lat_valid", 32'(r_bin_V_TVALID), 32'd1);
    chk("lat_data", 32'(r_bin_V_TDATA), 32'h12);
    send_hit(16'h07FF, 1'b1);
    finish_event(1'b1);

    // Out-of-range below and above.
    start_event();
    send_hit(16'hFFFB, 1'b0);
    send_hit(16'h0800, 1'b1);
    finish_event(1'b0);

    // Backpressure: two hits fill the buffer, third waits.
    start_event();
    r_bin_V_TREADY = 1'b0;
    send_hit(16'h0010, 1'b0);
    send_hit(16'h0020, 1'b0);
    chk("tready_full", 32'(hit_r_TREADY), 32'd0);
    chk("hold_valid", 32'(r_bin_V_TVALID), 32'd1);
    hit_r_TDATA  = 16'h0030;
    hit_r_TLAST  = 1'b1;
    hit_r_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", 32'(r_bin_V_TDATA), 32'h01);
      chk("tready_low", 32'(hit_r_TREADY), 32'd0);
    end
    r_bin_V_TREADY = 1'b1;
    send_hit(16'h0030, 1'b1);
    finish_event(1'b1);

    // Four hits with TLAST on the fourth, drain timing.
    start_event();
    for (int i = 1; i <= 4; i++) send_hit(16'(i * 256), (i == 4));
    finish_event(1'b1);

    // Single-hit event.
    start_event();
    send_hit(16'h0000, 1'b1);
    finish_event(1'b1);

    // Counter saturation with 260 out-of-range hits.
    start_event();
    for (int i = 0; i < 260; i++) send_hit(16'h8000 + 16'(i), (i == 259));
    finish_event(1'b0);

    // event_start while busy, then asynchronous reset mid-stream.
    start_event();
    send_hit(16'h0050, 1'b0);
    event_start = 1'b1;
    tick();
    event_start = 1'b0;
    chk("start_err", 32'(start_err), 32'd1);
    chk("no_restart_clr", 32'(reset_rbins), 32'd0);
    chk("no_restart_en", 32'(enable_V), 32'd1);
    chk("still_busy", 32'(busy), 32'd1);
    chk("t6_hits", 32'(hits_sent), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({hit_r_TREADY, r_bin_V_TDATA, r_bin_V_TVALID, reset_rbins, enable_V,
                            event_done, busy, hits_sent, oor_count, start_err}), 32'd0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'({busy, start_err}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
